// File: rtl/logic_pod_phase_shift_ctrl_if.sv
// Aligner request/response and MMCM dynamic phase-shift signals for the phase shift sequencer.
// The master side is the aligner plus MMCM; the slave side is the sequencer.
interface logic_pod_phase_shift_ctrl_if #(
    parameter int POS_WIDTH = 7
);
    logic                 req_en;
    logic                 req_inc;
    logic                 req_done;
    logic                 busy;
    logic [POS_WIDTH-1:0] position;
    logic                 timeout_err;
    logic                 proto_err;
    logic                 mmcm_psen;
    logic                 mmcm_psincdec;
    logic                 mmcm_psdone;
    logic                 mmcm_locked;

    modport master (
        output req_en, req_inc, mmcm_psdone, mmcm_locked,
        input  req_done, busy, position, timeout_err, proto_err, mmcm_psen, mmcm_psincdec
    );

    modport slave (
        input  req_en, req_inc, mmcm_psdone, mmcm_locked,
        output req_done, busy, position, timeout_err, proto_err, mmcm_psen, mmcm_psincdec
    );
endinterface

// File: rtl/logic_pod_phase_shift_ctrl.sv
// Sequences single-step MMCM fine phase shifts for the logic pod aligner, tracks the
// absolute phase position modulo one period and flags hung or illegal handshakes.
module logic_pod_phase_shift_ctrl #(
    parameter int STEPS_PER_PERIOD = 112,
    parameter int POS_WIDTH        = 7,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                          clk_312p5mhz,
    input  logic                          rst,
    logic_pod_phase_shift_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POS_WIDTH-1:0] POS_MAX  = POS_WIDTH'(STEPS_PER_PERIOD - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t               state_q, state_d;
    logic                 dir_q, dir_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 terr_q, terr_d;
    logic                 perr_q, perr_d;

    logic [CNT_W-1:0]     cnt_inc;
    logic                 timeout_hit;
    logic                 locked;

    assign locked      = bus.mmcm_locked;
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_LAST);

    always_ff @(posedge clk_312p5mhz) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            perr_q  <= perr_d;
        end
    end

    // Loss of lock overrides everything: the MMCM restarts at phase zero after relock.
    always_comb begin
        state_d = state_q;
        if (!locked) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.req_en) state_d = ISSUE;
                ISSUE:   state_d = WAIT;
                WAIT:    if (bus.mmcm_psdone || timeout_hit) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dir_d  = dir_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pos_d  = pos_q;
        cnt_d  = cnt_q;
        terr_d = terr_q;
        perr_d = perr_q;

        if (bus.req_en && busy_q)
            perr_d = 1'b1;
        if (bus.mmcm_psdone && (state_q != WAIT))
            perr_d = 1'b1;

        if (!locked) begin
            pos_d = '0;
            cnt_d = '0;
            if (busy_q) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                terr_d = 1'b1;
            end else if ((state_q == IDLE) && bus.req_en) begin
                done_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_en) begin
                        dir_d  = bus.req_inc;
                        busy_d = 1'b1;
                    end
                end
                ISSUE: cnt_d = '0;
                WAIT: begin
                    cnt_d = cnt_inc;
                    if (bus.mmcm_psdone) begin
                        if (dir_q)
                            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                        else
                            pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else if (timeout_hit) begin
                        terr_d = 1'b1;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // PSEN is gated by lock combinationally so it can never fire against an unlocked MMCM.
    always_comb begin
        bus.mmcm_psen     = (state_q == ISSUE) && locked;
        bus.mmcm_psincdec = (state_q != IDLE) && dir_q;
        bus.req_done      = done_q;
        bus.busy          = busy_q;
        bus.position      = pos_q;
        bus.timeout_err   = terr_q;
        bus.proto_err     = perr_q;
    end
endmodule
